// File: rtl/move_commit_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// move_commit_ctrl_pkg
// Purpose : shared cell codes, board geometry, FSM encodings and small helpers
//           for the move-commit controller in front of the five-in-a-row
//           checker chain.
// Contents: cell_t (EMPTY/P1/P2), state_t (IDLE/WRITE/ARM/CHECK/OVER),
//           board/pointer/counter widths, default watchdog limit.
// -----------------------------------------------------------------------------
package move_commit_ctrl_pkg;

  localparam int unsigned BOARD_DIM     = 16;
  localparam int unsigned NUM_CELLS     = BOARD_DIM * BOARD_DIM;
  localparam int unsigned CELL_W        = 2;
  localparam int unsigned BOARD_W       = NUM_CELLS * CELL_W;
  localparam int unsigned PTR_W         = 8;
  localparam int unsigned CNT_W         = 9;
  localparam int unsigned WD_W          = 10;
  localparam int unsigned CHECK_TIMEOUT_DEF = 1023;

  typedef enum logic [CELL_W-1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_ARM   = 3'd2,
    ST_CHECK = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Player who moves after p; anything that is not P1 hands the turn to P1.
  function automatic cell_t other_player(input cell_t p);
    return (p == CELL_P1) ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/move_commit_ctrl_if.sv
// -----------------------------------------------------------------------------
// move_commit_ctrl_if
// Purpose : bundles the move handshake, board/result outputs and the checker
//           chain control/status signals of move_commit_ctrl.
// Modports: slave  - the controller (drives ready/reject/board/result/check ctl)
//           master - the environment (drives moves, new_game, checker results)
// -----------------------------------------------------------------------------
interface move_commit_ctrl_if;
  import move_commit_ctrl_pkg::*;

  logic                     new_game;
  logic                     move_valid;
  logic [PTR_W-1:0]         move_ptr;
  logic                     move_ready;
  logic                     move_reject;
  logic [BOARD_W-1:0]       board;
  logic [PTR_W-1:0]         pointer;
  cell_t                    chess;
  logic                     check_reset;
  logic                     check_active;
  logic                     check_success;
  logic                     check_done;
  cell_t                    turn;
  logic                     game_over;
  cell_t                    winner;
  logic                     check_error;

  modport slave (
    input  new_game, move_valid, move_ptr, check_success, check_done,
    output move_ready, move_reject, board, pointer, chess, check_reset,
           check_active, turn, game_over, winner, check_error
  );

  modport master (
    output new_game, move_valid, move_ptr, check_success, check_done,
    input  move_ready, move_reject, board, pointer, chess, check_reset,
           check_active, turn, game_over, winner, check_error
  );

endinterface

// File: rtl/move_commit_ctrl_board_cell_rw.sv
// -----------------------------------------------------------------------------
// move_commit_ctrl_board_cell_rw
// Purpose : owns the 16x16 board register (2 bits per cell). Provides a
//           combinational read of one cell and a registered single-cell write;
//           a synchronous clear empties the whole board and wins over a write.
// Ports   : i_clk, i_reset   clock, async active-high reset
//           i_clear          synchronous board clear (new game)
//           i_wr_en/ptr/cell single-cell write
//           i_rd_ptr         read address
//           o_rd_cell_c      combinational read data
//           o_board          full board image
// -----------------------------------------------------------------------------
module move_commit_ctrl_board_cell_rw
  import move_commit_ctrl_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_wr_en,
  input  logic [PTR_W-1:0]   i_wr_ptr,
  input  cell_t              i_wr_cell,
  input  logic [PTR_W-1:0]   i_rd_ptr,
  output logic [CELL_W-1:0]  o_rd_cell_c,
  output logic [BOARD_W-1:0] o_board
);

  logic [BOARD_W-1:0] r_board;

  // Cell a lives at bits [2a+1:2a]; {ptr,0} is the bit offset.
  assign o_rd_cell_c = r_board[{i_rd_ptr, 1'b0} +: CELL_W];
  assign o_board     = r_board;

  // Board storage: clear has priority over the single-cell write.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_board <= '0;
    end else if (i_clear) begin
      r_board <= '0;
    end else if (i_wr_en) begin
      r_board[{i_wr_ptr, 1'b0} +: CELL_W] <= i_wr_cell;
    end
  end

endmodule

// File: rtl/move_commit_ctrl.sv
// -----------------------------------------------------------------------------
// move_commit_ctrl
// Purpose : upstream stage of the five-in-a-row checkers. Accepts one move per
//           turn, rejects occupied cells, commits legal moves to the board,
//           then arms and supervises the external checker chain and reports
//           win / draw / watchdog timeout. Alternates players between moves.
// Ports   : i_clk    system clock, rising edge
//           i_reset  asynchronous active-high reset
//           bus      move_commit_ctrl_if.slave (move handshake, board, result,
//                    checker control and status)
// -----------------------------------------------------------------------------
module move_commit_ctrl
  import move_commit_ctrl_pkg::*;
#(
  parameter int unsigned CHECK_TIMEOUT = CHECK_TIMEOUT_DEF,
  parameter cell_t       FIRST_PLAYER  = CELL_P1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  move_commit_ctrl_if.slave   bus
);

  // State and registered outputs
  state_t            r_state;
  logic [PTR_W-1:0]  r_pointer;
  cell_t             r_chess;
  cell_t             r_turn;
  logic [CNT_W-1:0]  r_move_count;
  logic [WD_W-1:0]   r_wd;
  logic              r_move_ready;
  logic              r_move_reject;
  logic              r_check_reset;
  logic              r_check_active;
  logic              r_game_over;
  cell_t             r_winner;
  logic              r_check_error;

  // Next-state / next-output values
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  w_pointer_nxt;
  cell_t             w_chess_nxt;
  cell_t             w_turn_nxt;
  logic [CNT_W-1:0]  w_move_count_nxt;
  logic [WD_W-1:0]   w_wd_nxt;
  logic              w_move_ready_nxt;
  logic              w_move_reject_nxt;
  logic              w_check_reset_nxt;
  logic              w_check_active_nxt;
  logic              w_game_over_nxt;
  cell_t             w_winner_nxt;
  logic              w_check_error_nxt;

  // Decoded events
  logic [CELL_W-1:0] w_rd_cell;
  logic [BOARD_W-1:0] w_board;
  logic              w_move_req;
  logic              w_accept;
  logic              w_reject;
  logic              w_check_win;
  logic              w_check_fail;
  logic              w_timeout;
  logic              w_board_full;

  move_commit_ctrl_board_cell_rw u_board (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (bus.new_game),
    .i_wr_en     (r_state == ST_WRITE),
    .i_wr_ptr    (r_pointer),
    .i_wr_cell   (r_chess),
    .i_rd_ptr    (bus.move_ptr),
    .o_rd_cell_c (w_rd_cell),
    .o_board     (w_board)
  );

  // new_game masks every other event in the same cycle.
  assign w_move_req   = (r_state == ST_IDLE) && bus.move_valid && !bus.new_game;
  assign w_accept     = w_move_req && (w_rd_cell == CELL_EMPTY);
  assign w_reject     = w_move_req && (w_rd_cell != CELL_EMPTY);
  // Success outranks done; done outranks the watchdog.
  assign w_check_win  = (r_state == ST_CHECK) && !bus.new_game && bus.check_success;
  assign w_check_fail = (r_state == ST_CHECK) && !bus.new_game && !bus.check_success
                        && bus.check_done;
  assign w_timeout    = (r_state == ST_CHECK) && !bus.new_game && !bus.check_success
                        && !bus.check_done && (r_wd == WD_W'(CHECK_TIMEOUT));
  assign w_board_full = (r_move_count == CNT_W'(NUM_CELLS));

  // State register and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_pointer      <= '0;
      r_chess        <= CELL_EMPTY;
      r_turn         <= FIRST_PLAYER;
      r_move_count   <= '0;
      r_wd           <= '0;
      r_move_ready   <= 1'b1;
      r_move_reject  <= 1'b0;
      r_check_reset  <= 1'b0;
      r_check_active <= 1'b0;
      r_game_over    <= 1'b0;
      r_winner       <= CELL_EMPTY;
      r_check_error  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pointer      <= w_pointer_nxt;
      r_chess        <= w_chess_nxt;
      r_turn         <= w_turn_nxt;
      r_move_count   <= w_move_count_nxt;
      r_wd           <= w_wd_nxt;
      r_move_ready   <= w_move_ready_nxt;
      r_move_reject  <= w_move_reject_nxt;
      r_check_reset  <= w_check_reset_nxt;
      r_check_active <= w_check_active_nxt;
      r_game_over    <= w_game_over_nxt;
      r_winner       <= w_winner_nxt;
      r_check_error  <= w_check_error_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.new_game) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept) w_state_nxt = ST_WRITE;
        ST_WRITE: w_state_nxt = ST_ARM;
        ST_ARM:   w_state_nxt = ST_CHECK;
        ST_CHECK: begin
          if (w_check_win || w_timeout)  w_state_nxt = ST_OVER;
          else if (w_check_fail)         w_state_nxt = w_board_full ? ST_OVER : ST_IDLE;
        end
        ST_OVER:  w_state_nxt = ST_OVER;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output / datapath logic; levels are decoded from the next state so they
  // line up with the state they describe.
  always_comb begin
    w_pointer_nxt      = r_pointer;
    w_chess_nxt        = r_chess;
    w_turn_nxt         = r_turn;
    w_move_count_nxt   = r_move_count;
    w_game_over_nxt    = r_game_over;
    w_winner_nxt       = r_winner;
    w_check_error_nxt  = r_check_error;
    w_wd_nxt           = (r_state == ST_CHECK) ? r_wd + WD_W'(1) : '0;
    w_move_ready_nxt   = (w_state_nxt == ST_IDLE);
    w_check_active_nxt = (w_state_nxt == ST_CHECK);
    w_check_reset_nxt  = bus.new_game || (w_state_nxt == ST_ARM);
    w_move_reject_nxt  = w_reject;

    if (bus.new_game) begin
      w_pointer_nxt     = '0;
      w_chess_nxt       = CELL_EMPTY;
      w_turn_nxt        = FIRST_PLAYER;
      w_move_count_nxt  = '0;
      w_game_over_nxt   = 1'b0;
      w_winner_nxt      = CELL_EMPTY;
      w_check_error_nxt = 1'b0;
    end else begin
      if (w_accept) begin
        w_pointer_nxt = bus.move_ptr;
        w_chess_nxt   = r_turn;
      end
      if (r_state == ST_WRITE) begin
        w_move_count_nxt = r_move_count + CNT_W'(1);
      end
      if (w_check_win) begin
        w_game_over_nxt = 1'b1;
        w_winner_nxt    = r_chess;
      end
      if (w_check_fail) begin
        if (w_board_full) begin
          w_game_over_nxt = 1'b1;
          w_winner_nxt    = CELL_EMPTY;
        end else begin
          w_turn_nxt = other_player(r_turn);
        end
      end
      if (w_timeout) begin
        w_check_error_nxt = 1'b1;
        w_game_over_nxt   = 1'b1;
        w_winner_nxt      = CELL_EMPTY;
      end
    end
  end

  assign bus.move_ready   = r_move_ready;
  assign bus.move_reject  = r_move_reject;
  assign bus.board        = w_board;
  assign bus.pointer      = r_pointer;
  assign bus.chess        = r_chess;
  assign bus.check_reset  = r_check_reset;
  assign bus.check_active = r_check_active;
  assign bus.turn         = r_turn;
  assign bus.game_over    = r_game_over;
  assign bus.winner       = r_winner;
  assign bus.check_error  = r_check_error;

endmodule

// File: tb/tb_move_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_move_commit_ctrl
// Purpose : directed self-checking bench for move_commit_ctrl. Inputs change
//           1 time unit after each rising edge and outputs are sampled there.
//           A small board/turn model supplies expected board images.
// -----------------------------------------------------------------------------
module tb_move_commit_ctrl;
  import move_commit_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [BOARD_W-1:0] m_board;
  logic [1:0]         m_turn;
  int                 m_count;
  logic [BOARD_W-1:0] snap;
  int                 n_act;

  move_commit_ctrl_if bus();

  move_commit_ctrl dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BOARD_W-1:0] obs,
                     input logic [BOARD_W-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_board = '0;
    m_turn  = 2'b01;
    m_count = 0;
  endtask

  task automatic new_game();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    model_clear();
  endtask

  // Full legal move: accept, WRITE, ARM, one CHECK cycle with given results.
  task automatic play(input logic [7:0] p, input logic s, input logic d);
    bus.move_valid = 1'b1;
    bus.move_ptr   = p;
    tick();
    bus.move_valid = 1'b0;
    m_board[{p, 1'b0} +: 2] = m_turn;
    m_count++;
    tick();
    tick();
    bus.check_success = s;
    bus.check_done    = d;
    tick();
    bus.check_success = 1'b0;
    bus.check_done    = 1'b0;
    if (!s && d && m_count != 256) m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_clear();
    rst               = 1'b1;
    bus.new_game      = 1'b0;
    bus.move_valid    = 1'b0;
    bus.move_ptr      = '0;
    bus.check_success = 1'b0;
    bus.check_done    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state, first move latency, turn change
    chk("rst_board",     bus.board,        '0);
    chk("rst_turn",      bus.turn,         2'b01);
    chk("rst_ready",     bus.move_ready,   1'b1);
    chk("rst_over",      bus.game_over,    1'b0);
    chk("rst_winner",    bus.winner,       2'b00);
    chk("rst_err",       bus.check_error,  1'b0);
    chk("rst_creset",    bus.check_reset,  1'b0);
    chk("rst_cactive",   bus.check_active, 1'b0);
    chk("rst_pointer",   bus.pointer,      8'h00);
    chk("rst_chess",     bus.chess,        2'b00);

    bus.move_valid = 1'b1;
    bus.move_ptr   = 8'h00;
    tick();                          // edge N: accepted
    bus.move_valid = 1'b0;
    chk("w_ready",       bus.move_ready,   1'b0);
    chk("w_chess",       bus.chess,        2'b01);
    chk("w_board",       bus.board,        '0);
    chk("w_creset",      bus.check_reset,  1'b0);
    tick();                          // cycle N+2: ARM
    chk("arm_board",     bus.board[1:0],   2'b01);
    chk("arm_creset",    bus.check_reset,  1'b1);
    chk("arm_cactive",   bus.check_active, 1'b0);
    tick();                          // cycle N+3: CHECK
    chk("chk_cactive",   bus.check_active, 1'b1);
    chk("chk_creset",    bus.check_reset,  1'b0);
    bus.check_done = 1'b1;
    tick();
    bus.check_done = 1'b0;
    chk("t1_turn",       bus.turn,         2'b10);
    chk("t1_ready",      bus.move_ready,   1'b1);
    chk("t1_cactive",    bus.check_active, 1'b0);
    m_board[1:0] = 2'b01;
    m_turn       = 2'b10;
    m_count      = 1;

    // 2: reject on occupied cell
    play(8'h10, 1'b0, 1'b1);         // P2
    play(8'h37, 1'b0, 1'b1);         // P1
    chk("t2_turn_pre",   bus.turn,         2'b10);
    snap = bus.board;
    bus.move_valid = 1'b1;
    bus.move_ptr   = 8'h37;
    tick();
    bus.move_valid = 1'b0;
    chk("t2_reject",     bus.move_reject,  1'b1);
    chk("t2_ready",      bus.move_ready,   1'b1);
    tick();
    chk("t2_reject_end", bus.move_reject,  1'b0);
    chk("t2_board",      bus.board,        snap);
    chk("t2_board_mdl",  bus.board,        m_board);
    chk("t2_turn",       bus.turn,         2'b10);
    chk("t2_pointer",    bus.pointer,      8'h37);

    // 3: P1 five in row 5; success together with done wins
    for (int c = 0; c < 5; c++) begin
      play(8'h90 + 8'(c), 1'b0, 1'b1);
      play(8'h50 + 8'(c), (c == 4), 1'b1);
    end
    chk("t3_over",       bus.game_over,    1'b1);
    chk("t3_winner",     bus.winner,       2'b01);
    chk("t3_ready",      bus.move_ready,   1'b0);
    chk("t3_board",      bus.board,        m_board);
    snap = bus.board;
    bus.move_valid = 1'b1;
    bus.move_ptr   = 8'hA0;
    tick();
    chk("t3_noreject",   bus.move_reject,  1'b0);
    tick();
    tick();
    bus.move_valid = 1'b0;
    chk("t3_ignored",    bus.board,        snap);
    chk("t3_cactive",    bus.check_active, 1'b0);
    chk("t3_over_hold",  bus.game_over,    1'b1);

    // 4: new_game, then fill the board -> draw
    new_game();
    chk("ng_creset",     bus.check_reset,  1'b1);
    chk("ng_board",      bus.board,        '0);
    chk("ng_turn",       bus.turn,         2'b01);
    chk("ng_over",       bus.game_over,    1'b0);
    chk("ng_ready",      bus.move_ready,   1'b1);
    for (int i = 0; i < 255; i++) play(8'(i), 1'b0, 1'b1);
    chk("t4_over_255",   bus.game_over,    1'b0);
    chk("t4_turn_255",   bus.turn,         2'b10);
    play(8'hFF, 1'b0, 1'b1);
    chk("t4_over",       bus.game_over,    1'b1);
    chk("t4_winner",     bus.winner,       2'b00);
    chk("t4_ready",      bus.move_ready,   1'b0);
    chk("t4_board",      bus.board,        m_board);
    chk("t4_err",        bus.check_error,  1'b0);

    // 5: watchdog
    new_game();
    bus.move_valid = 1'b1;
    bus.move_ptr   = 8'h00;
    tick();
    bus.move_valid = 1'b0;
    tick();
    tick();
    n_act = 0;
    while (bus.check_active && n_act < 2000) begin
      n_act++;
      tick();
    end
    chk("t5_cycles",     32'(n_act),       32'(CHECK_TIMEOUT_DEF + 1));
    chk("t5_err",        bus.check_error,  1'b1);
    chk("t5_over",       bus.game_over,    1'b1);
    chk("t5_winner",     bus.winner,       2'b00);
    chk("t5_ready",      bus.move_ready,   1'b0);

    // 6: new_game aborts CHECK; async reset during WRITE
    new_game();
    chk("t6_err_clr",    bus.check_error,  1'b0);
    bus.move_valid = 1'b1;
    bus.move_ptr   = 8'h00;
    tick();
    bus.move_valid = 1'b0;
    tick();
    tick();
    chk("t6_in_check",   bus.check_active, 1'b1);
    new_game();
    chk("t6_ng_creset",  bus.check_reset,  1'b1);
    chk("t6_ng_cactive", bus.check_active, 1'b0);
    chk("t6_ng_ready",   bus.move_ready,   1'b1);
    chk("t6_ng_board",   bus.board,        '0);
    chk("t6_ng_turn",    bus.turn,         2'b01);
    tick();
    chk("t6_ng_cr_end",  bus.check_reset,  1'b0);
    chk("t6_ng_idle",    bus.check_active, 1'b0);
    bus.move_valid = 1'b1;
    bus.move_ptr   = 8'h12;
    tick();                          // now in WRITE
    bus.move_valid = 1'b0;
    chk("t6_write",      bus.move_ready,   1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_board",  bus.board,        '0);
    chk("t6_rst_turn",   bus.turn,         2'b01);
    chk("t6_rst_ready",  bus.move_ready,   1'b1);
    chk("t6_rst_ptr",    bus.pointer,      8'h00);
    chk("t6_rst_chess",  bus.chess,        2'b00);
    chk("t6_rst_cr",     bus.check_reset,  1'b0);
    chk("t6_rst_ca",     bus.check_active, 1'b0);
    chk("t6_rst_over",   bus.game_over,    1'b0);
    chk("t6_rst_err",    bus.check_error,  1'b0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("t6_post_board", bus.board,        '0);
    chk("t6_post_ready", bus.move_ready,   1'b1);
    chk("t6_post_ca",    bus.check_active, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
